fp_complex_mac_sequencer: RTL and testbench



---
 rtl/fp_complex_mac_sequencer.sv | 98 +++++++++
 tb/tb_fp_complex_mac_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fp_complex_mac_sequencer.sv
// fp_complex_mac_sequencer: feeds len complex pairs through an external iterative multiplier and sums the products (FP_CMAC_CONJ_EN: sum a*conj(b))
module fp_complex_mac_sequencer #(
  parameter int n = 32,
  parameter int d = 16,
  parameter int len = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [n-1:0] ar,
  input  logic [n-1:0] ac,
  input  logic [n-1:0] br,
  input  logic [n-1:0] bc,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [n-1:0] sr,
  output logic [n-1:0] sc,
  output logic         mul_recv_val,
  input  logic         mul_recv_rdy,
  output logic [n-1:0] mul_ar,
  output logic [n-1:0] mul_ac,
  output logic [n-1:0] mul_br,
  output logic [n-1:0] mul_bc,
  input  logic         mul_send_val,
  output logic         mul_send_rdy,
  input  logic [n-1:0] mul_cr,
  input  logic [n-1:0] mul_cc
);
  localparam int cw = $clog2(len + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nxt;
  logic [cw-1:0] count;
  logic [n-1:0] acc_r, acc_c, op_ar, op_ac, op_br, op_bc;
  logic last;
  if (len < 1 || d < 0 || d >= n) begin : g_bad_params
    $error("fp_complex_mac_sequencer: need len >= 1 and 0 <= d < n");
  end
  assign last = count == cw'(len - 1);
  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nxt;
  // next-state: one term per IDLE->ISSUE->WAIT loop, DONE after the len-th product
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = recv_val ? ISSUE : IDLE;
      ISSUE:   state_nxt = mul_recv_rdy ? WAIT : ISSUE;
      WAIT:    state_nxt = mul_send_val ? (last ? DONE : IDLE) : WAIT;
      default: state_nxt = send_rdy ? IDLE : DONE;
    endcase
  end
  // handshake outputs decoded from registered state only
  always_comb begin
    recv_rdy     = state == IDLE;
    mul_recv_val = state == ISSUE;
    mul_send_rdy = state == WAIT;
    send_val     = state == DONE;
  end
  // operand capture, accumulation and per-block clear
  always_ff @(posedge clk)
    if (reset) begin
      op_ar <= '0;
      op_ac <= '0;
      op_br <= '0;
      op_bc <= '0;
      acc_r <= '0;
      acc_c <= '0;
      count <= '0;
    end else begin
      if (state == IDLE && recv_val) begin
        op_ar <= ar;
        op_ac <= ac;
        op_br <= br;
`ifdef FP_CMAC_CONJ_EN
        op_bc <= -bc;
`else
        op_bc <= bc;
`endif
      end
      if (state == WAIT && mul_send_val) begin
        acc_r <= acc_r + mul_cr;
        acc_c <= acc_c + mul_cc;
        count <= count + 1'b1;
      end
      if (state == DONE && send_rdy) begin
        acc_r <= '0;
        acc_c <= '0;
        count <= '0;
      end
    end
  assign mul_ar = op_ar;
  assign mul_ac = op_ac;
  assign mul_br = op_br;
  assign mul_bc = op_bc;
  assign sr = acc_r;
  assign sc = acc_c;
endmodule

// File: tb/tb_fp_complex_mac_sequencer.sv
// tb_fp_complex_mac_sequencer: directed and randomized checks against a complex-arithmetic reference model
module tb_fp_complex_mac_sequencer;
  localparam int N = 32;
  localparam int D = 16;
  localparam int LEN = 2;
`ifdef FP_CMAC_CONJ_EN
  localparam bit CONJ = 1'b1;
`else
  localparam bit CONJ = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic recv_val = 1'b0, send_rdy = 1'b0, mul_recv_rdy = 1'b0, mul_send_val = 1'b0;
  logic [N-1:0] ar = '0, ac = '0, br = '0, bc = '0, mul_cr = '0, mul_cc = '0;
  logic recv_rdy, send_val, mul_recv_val, mul_send_rdy;
  logic [N-1:0] sr, sc, mul_ar, mul_ac, mul_br, mul_bc;
  logic [N-1:0] er = '0, ec = '0;
  int vectors = 0, errs = 0;
  fp_complex_mac_sequencer #(.n(N), .d(D), .len(LEN)) dut (
    .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(recv_rdy),
    .ar(ar), .ac(ac), .br(br), .bc(bc), .send_val(send_val), .send_rdy(send_rdy),
    .sr(sr), .sc(sc), .mul_recv_val(mul_recv_val), .mul_recv_rdy(mul_recv_rdy),
    .mul_ar(mul_ar), .mul_ac(mul_ac), .mul_br(mul_br), .mul_bc(mul_bc),
    .mul_send_val(mul_send_val), .mul_send_rdy(mul_send_rdy), .mul_cr(mul_cr), .mul_cc(mul_cc)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
    vectors++;
    assert (obs === want) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask
  function automatic logic [2*N-1:0] cmul(input logic signed [N-1:0] a_r, a_c, b_r, b_c);
    longint pr, pc;
    pr = (longint'(a_r) * longint'(b_r) - longint'(a_c) * longint'(b_c)) >>> D;
    pc = (longint'(a_r) * longint'(b_c) + longint'(a_c) * longint'(b_r)) >>> D;
    return {pr[N-1:0], pc[N-1:0]};
  endfunction
  function automatic logic [N-1:0] rnd();
    logic [31:0] r;
    r = $urandom;
    return {{12{r[19]}}, r[19:0]};
  endfunction
  // one term: accept, optional issue stall, multiplier latency, product return
  task automatic term(input logic [N-1:0] a_r, a_c, b_r, b_c, input int st, lat,
                      input bit ovr, input logic [N-1:0] pr, pc);
    logic [N-1:0] bi;
    logic [2*N-1:0] p;
    bi = CONJ ? N'(0) - b_c : b_c;
    p = ovr ? {pr, pc} : cmul(a_r, a_c, b_r, bi);
    chk("idle_rdy", {send_val, recv_rdy}, 2'b01);
    ar = a_r; ac = a_c; br = b_r; bc = b_c; recv_val = 1'b1;
    step;
    recv_val = 1'b0;
    chk("issue_val", {recv_rdy, mul_recv_val, mul_send_rdy}, 3'b010);
    chk("issue_ops", {mul_ar, mul_ac, mul_br, mul_bc}, {a_r, a_c, b_r, bi});
    for (int i = 0; i < st; i++) begin
      recv_val = 1'b1; ar = rnd(); bc = rnd();
      mul_send_val = 1'b1; mul_cr = rnd(); mul_cc = rnd();
      step;
      chk("stall_ops", {mul_ar, mul_ac, mul_br, mul_bc}, {a_r, a_c, b_r, bi});
      chk("stall_hs", {recv_rdy, mul_recv_val}, 2'b01);
    end
    recv_val = 1'b0; mul_send_val = 1'b0; mul_recv_rdy = 1'b1;
    step;
    mul_recv_rdy = 1'b0;
    chk("wait_hs", {mul_recv_val, mul_send_rdy, recv_rdy}, 3'b010);
    for (int i = 1; i < lat; i++) step;
    chk("wait_ops", {mul_ar, mul_ac, mul_br, mul_bc}, {a_r, a_c, b_r, bi});
    {mul_cr, mul_cc} = p; mul_send_val = 1'b1;
    step;
    mul_send_val = 1'b0;
    er = er + p[2*N-1:N];
    ec = ec + p[N-1:0];
  endtask
  // DONE phase: hold send_rdy low for a while, then hand the sum off
  task automatic finish_blk(input int hold);
    for (int i = 0; i < hold; i++) begin
      chk("done_hold", {send_val, recv_rdy, mul_recv_val, mul_send_rdy, sr, sc}, {4'b1000, er, ec});
      step;
    end
    chk("done_sum", {send_val, recv_rdy, mul_recv_val, mul_send_rdy, sr, sc}, {4'b1000, er, ec});
    send_rdy = 1'b1;
    step;
    send_rdy = 1'b0;
    chk("post_send", {send_val, recv_rdy, sr, sc}, {2'b01, {2*N{1'b0}}});
    er = '0; ec = '0;
  endtask
  initial begin
    step; step;
    chk("reset_vals", {recv_rdy, send_val, mul_recv_val, mul_send_rdy, sr, sc},
        {4'b1000, {2*N{1'b0}}});
    chk("reset_ops", {mul_ar, mul_ac, mul_br, mul_bc}, '0);
    reset = 1'b0;
    step;
    // single block: (1+1j)(1+0j) + (0+1j)(0+1j)
    term(32'h00010000, 32'h00010000, 32'h00010000, 32'h0, 0, 1, 1'b0, '0, '0);
    term(32'h0, 32'h00010000, 32'h0, 32'h00010000, 0, 2, 1'b0, '0, '0);
    if (!CONJ) chk("single_const", {sr, sc}, {32'h0, 32'h00010000});
    finish_blk(0);
    chk("single_once", {send_val, recv_rdy}, 2'b01);
    // backpressure on issue and on the sum
    term(32'h00020000, 32'h00010000, 32'h00030000, 32'hFFFF0000, 5, 3, 1'b0, '0, '0);
    term(32'hFFFE0000, 32'h00008000, 32'h00010000, 32'h00020000, 0, 1, 1'b0, '0, '0);
    finish_blk(4);
    step;
    chk("bp_one_out", {send_val, recv_rdy}, 2'b01);
    // wrap: 0x7FFF0000 + 0x00020000
    term(32'h1, 32'h0, 32'h1, 32'h0, 0, 1, 1'b1, 32'h7FFF0000, 32'h0);
    term(32'h1, 32'h0, 32'h1, 32'h0, 0, 1, 1'b1, 32'h00020000, 32'h0);
    chk("wrap_sr", sr, 32'h80010000);
    finish_blk(1);
    // reset mid-WAIT with one product already accumulated
    term(32'h00010000, 32'h0, 32'h00010000, 32'h0, 0, 1, 1'b0, '0, '0);
    ar = 32'h00010000; ac = 32'h00010000; br = 32'h00010000; bc = 32'h00010000; recv_val = 1'b1;
    step;
    recv_val = 1'b0; mul_recv_rdy = 1'b1;
    step;
    mul_recv_rdy = 1'b0;
    chk("pre_rst_wait", mul_send_rdy, 1'b1);
    reset = 1'b1;
    step;
    reset = 1'b0;
    chk("rst_mid_wait", {recv_rdy, send_val, mul_recv_val, mul_send_rdy, sr, sc}, {4'b1000, {2*N{1'b0}}});
    chk("rst_ops", {mul_ar, mul_ac, mul_br, mul_bc}, '0);
    mul_cr = 32'h00050000; mul_cc = 32'h00070000; mul_send_val = 1'b1;
    step;
    mul_send_val = 1'b0;
    chk("late_product", {recv_rdy, sr, sc}, {1'b1, {2*N{1'b0}}});
    er = '0; ec = '0;
    term(32'h00030000, 32'h0, 32'h00010000, 32'h0, 0, 1, 1'b0, '0, '0);
    chk("rst_count", send_val, 1'b0);
    term(32'h00010000, 32'h0, 32'h00010000, 32'h0, 1, 2, 1'b0, '0, '0);
    finish_blk(0);
`ifdef FP_CMAC_CONJ_EN
    // conjugate: (0+1j)*conj(0+1j) = 1
    term(32'h0, 32'h00010000, 32'h0, 32'h00010000, 0, 1, 1'b0, '0, '0);
    chk("conj_bc", mul_bc, 32'hFFFF0000);
    term(32'h0, 32'h0, 32'h0, 32'h0, 0, 1, 1'b0, '0, '0);
    chk("conj_sr", {sr, sc}, {32'h00010000, 32'h0});
    finish_blk(0);
`endif
    // back-to-back blocks with send_rdy held high
    for (int b = 0; b < 2; b++) begin
      term(rnd(), rnd(), rnd(), rnd(), 0, 1, 1'b0, '0, '0);
      term(rnd(), rnd(), rnd(), rnd(), 0, 1, 1'b0, '0, '0);
      chk("b2b_sum", {send_val, sr, sc}, {1'b1, er, ec});
      send_rdy = 1'b1;
      step;
      chk("b2b_clear", {send_val, recv_rdy, sr, sc}, {2'b01, {2*N{1'b0}}});
      er = '0; ec = '0;
    end
    send_rdy = 1'b0;
    // randomized blocks with random stalls, latencies and output holds
    for (int b = 0; b < 8; b++) begin
      for (int t = 0; t < LEN; t++)
        term(rnd(), rnd(), rnd(), rnd(), int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), 1'b0, '0, '0);
      finish_blk(int'($urandom_range(0, 3)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
